hamming_12_8_tx: RTL and testbench
==================================

Name: hamming_12_8_tx

Overview:
- Transmit-side partner of the Hamming(12,8) single-error-correcting decoder.
- Accepts 8-bit bytes over a valid/ready handshake and encodes each into a 12-bit codeword using the decoder's exact bit map.
- Presents the codeword in parallel and shifts it out serially, LSB (code[0]) first, with a frame strobe.
- Holds one pending byte, so the next byte can be accepted while the current frame is shifting.

Parameters:
- GAP_CYCLES, 2: number of cycles tx_frame stays low between back-to-back frames; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  byte to encode.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the pending register is empty; a byte is accepted when in_valid and in_ready are both high at a rising edge.
- code_out  output  12  last loaded codeword; held until the next load.
- code_valid  output  1  one-cycle pulse when code_out is updated.
- tx_bit  output  1  serial codeword bit.
- tx_frame  output  1  high exactly while the 12 codeword bits are on tx_bit.
- busy  output  1  high when the state is not IDLE or a byte is pending.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Bit map, c = codeword, d = byte:
  - Data bits: c[2]=d7, c[4]=d6, c[5]=d5, c[6]=d4, c[8]=d3, c[9]=d2, c[10]=d1, c[11]=d0.
  - Parity bits: c[0]=d7^d6^d4^d3^d1; c[1]=d7^d5^d4^d2^d1; c[3]=d6^d5^d4^d0; c[7]=d3^d2^d1^d0.
  - Every valid codeword therefore gives syndrome 0 at the decoder.
- Reset, while rst is high at a rising edge:
  - code_out=0, code_valid=0, tx_bit=0, tx_frame=0, busy=0, in_ready=1.
  - Pending register cleared, state IDLE, all counters 0.
  - Reset mid-frame aborts the frame immediately; the partial frame and any pending byte are discarded.
- Handshake:
  - in_ready is 1 exactly when no byte is pending; it is registered state, with no combinational path from in_valid.
  - An accepted byte goes into the pending register.
  - in_data is don't-care when in_valid=0.
- States:
  - IDLE: if a byte is pending, encode it and load the shift register and code_out, pulse code_valid, clear pending, set the bit counter to 0, and go to SHIFT.
  - SHIFT: tx_frame=1 and tx_bit=c[bitcnt]; bitcnt increments each cycle. After bitcnt=11, go to GAP.
  - GAP: tx_frame=0 and tx_bit=0. Stay for GAP_CYCLES-1 cycles, then go to IDLE. With GAP_CYCLES=1, go straight to IDLE.
- Latency:
  - Byte accepted at edge N means the load happens at edge N+1.
  - tx_frame=1 with c[0] is visible from edge N+1 through edge N+13.
- Back-to-back:
  - A byte accepted during SHIFT or GAP is held pending.
  - tx_frame is low for exactly GAP_CYCLES cycles (GAP cycles plus the IDLE load cycle) between frames.
  - Sustained throughput is one byte per 12+GAP_CYCLES cycles.
- Simultaneous events:
  - An accept and a load in the same cycle cannot occur, because a load requires a pending byte and that forces in_ready=0.
  - Pending is cleared at the load edge, so in_ready rises the following cycle.
- code_out changes only at a load. code_valid pulses exactly once per frame.

Optional Feature:
- Macro: HAMMING_TX_ERR_INJ_EN.
- Defined:
  - Adds ports inj_en (input, 1) and inj_pos (input, 4), sampled together with the accepted byte and stored with it.
  - At load, if inj_en=1 and inj_pos is in 1..12, bit c[inj_pos-1] is inverted in both code_out and the serial frame.
  - inj_pos of 0 or 13..15 means no flip.
  - The decoder then reports syndrome=inj_pos and corrects the bit.
- Not defined:
  - Neither port exists and every codeword is clean.

Test Plan:
- Reset: hold rst 3 cycles mid-frame -> all outputs at reset values the next cycle and in_ready=1; the partial frame is discarded.
- Single byte 8'hA5 -> code_out=12'hA27, one code_valid pulse, tx_frame high 12 cycles, tx_bit LSB first 1,1,1,0,0,1,0,0,0,1,0,1.
- Bytes 8'h00 and 8'hFF -> code_out=12'h000 and 12'hF77; feeding each into the decoder gives syndrome 0 and returns the original byte.
- Back-to-back 8'h3C and 8'hC3 with in_valid held high, GAP_CYCLES=2 -> second byte accepted during the first frame; in_ready low until the second load; tx_frame low exactly 2 cycles between frames.
- Random 1000 bytes with random in_valid gaps, with a scoreboard through the decoder -> every byte recovered in order with syndrome 0.
- With HAMMING_TX_ERR_INJ_EN: 8'hA5 with inj_pos=5 -> code_out=12'hA37; decoder syndrome 5 and recovered byte 8'hA5. With inj_pos=0 -> code_out=12'hA27.

Source files
------------

// File: rtl/hamming_12_8_tx.sv
// hamming_12_8_tx: Hamming(12,8) encoder with one-byte pending buffer and LSB-first serial framer.
// Optional error injection is enabled by defining HAMMING_TX_ERR_INJ_EN.
module hamming_12_8_tx #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
`ifdef HAMMING_TX_ERR_INJ_EN
  input  logic        inj_en,
  input  logic [3:0]  inj_pos,
`endif
  output logic        in_ready,
  output logic [11:0] code_out,
  output logic        code_valid,
  output logic        tx_bit,
  output logic        tx_frame,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 2);
  state_t      state;
  logic        pend;
  logic [7:0]  pend_data;
  logic [11:0] sh;
  logic [11:0] flip;
  logic [11:0] code;
  logic [3:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  function automatic logic [11:0] enc(input logic [7:0] d);
    return {d[0], d[1], d[2], d[3], d[3]^d[2]^d[1]^d[0], d[4], d[5], d[6],
            d[6]^d[5]^d[4]^d[0], d[7], d[7]^d[5]^d[4]^d[2]^d[1], d[7]^d[6]^d[4]^d[3]^d[1]};
  endfunction
`ifdef HAMMING_TX_ERR_INJ_EN
  logic       pend_inj;
  logic [3:0] pend_pos;
  always_ff @(posedge clk)
    if (rst) begin
      pend_inj <= 1'b0;
      pend_pos <= '0;
    end else if (in_valid && !pend) begin
      pend_inj <= inj_en;
      pend_pos <= inj_pos;
    end
  assign flip = (pend_inj && pend_pos != 4'd0 && pend_pos <= 4'd12) ? 12'd1 << (pend_pos - 4'd1) : '0;
`else
  assign flip = '0;
`endif
  assign code     = enc(pend_data) ^ flip;
  assign in_ready = !pend;
  assign busy     = state != IDLE || pend;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      pend_data  <= '0;
      sh         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
      tx_bit     <= 1'b0;
      tx_frame   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (in_valid && !pend) begin
        pend      <= 1'b1;
        pend_data <= in_data;
      end
      case (state)
        IDLE:
          if (pend) begin
            pend       <= 1'b0;
            sh         <= code;
            code_out   <= code;
            code_valid <= 1'b1;
            tx_bit     <= code[0];
            tx_frame   <= 1'b1;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
        SHIFT:
          if (bit_cnt == 4'd11) begin
            tx_frame <= 1'b0;
            tx_bit   <= 1'b0;
            gap_cnt  <= '0;
            state    <= GAP_CYCLES == 1 ? IDLE : GAP;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            tx_bit  <= sh[1];
            sh      <= sh >> 1;
          end
        GAP:
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 4'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hamming_12_8_tx.sv
// tb_hamming_12_8_tx: randomized scoreboard bench for hamming_12_8_tx with a positional Hamming model and decoder.
module tb_hamming_12_8_tx;
  localparam int GAP_CYCLES = 2;
  typedef struct {logic [11:0] code; logic [3:0] syn; logic [7:0] data;} exp_t;
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic in_valid = 0;
  logic in_ready, code_valid, tx_bit, tx_frame, busy;
  logic [11:0] code_out;
`ifdef HAMMING_TX_ERR_INJ_EN
  logic inj_en = 0;
  logic [3:0] inj_pos = 0;
`endif
  exp_t q[$];
  int tests = 0, fails = 0;
  int flen = 0, glen = 0, last_gap = -1;
  bit started = 0, prev_frame = 0;
  logic [11:0] ser = 0, last_code = 0;

  hamming_12_8_tx #(.GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef HAMMING_TX_ERR_INJ_EN
    .inj_en(inj_en), .inj_pos(inj_pos),
`endif
    .in_ready(in_ready), .code_out(code_out), .code_valid(code_valid),
    .tx_bit(tx_bit), .tx_frame(tx_frame), .busy(busy));

  always #5 clk = ~clk;

  // Data bits sit at the non-power-of-two positions 3,5,6,7,9,10,11,12 (d7 first).
  function automatic logic [11:0] model_enc(input logic [7:0] d, input bit e, input logic [3:0] p);
    int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [11:0] c = '0;
    logic x;
    for (int k = 0; k < 8; k++) c[dpos[k]-1] = d[7-k];
    for (int b = 0; b < 4; b++) begin
      x = 1'b0;
      for (int i = 1; i <= 12; i++) if (i[b]) x ^= c[i-1];
      c[(1 << b)-1] = x;
    end
    if (e && p >= 1 && p <= 12) c[p-1] = ~c[p-1];
    return c;
  endfunction

  function automatic void model_dec(input logic [11:0] c, output logic [3:0] s, output logic [7:0] d);
    int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [11:0] cc = c;
    s = '0;
    for (int i = 1; i <= 12; i++) if (c[i-1]) s ^= 4'(i);
    if (s >= 1 && s <= 12) cc[s-1] = ~cc[s-1];
    for (int k = 0; k < 8; k++) d[7-k] = cc[dpos[k]-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_code_out", code_out, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_tx_bit", tx_bit, 0);
    chk("rst_tx_frame", tx_frame, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input bit e, input logic [3:0] p);
    int n = 0;
    exp_t x;
    in_data = d;
    in_valid = 1;
`ifdef HAMMING_TX_ERR_INJ_EN
    inj_en = e;
    inj_pos = p;
`endif
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
`ifdef HAMMING_TX_ERR_INJ_EN
      x.code = model_enc(d, e, p);
      x.syn = (e && p >= 1 && p <= 12) ? p : 4'd0;
`else
      x.code = model_enc(d, 0, 0);
      x.syn = 4'd0;
`endif
      x.data = d;
      q.push_back(x);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_cv();
    int n = 0;
    while (!code_valid && n < 40) begin @(negedge clk); n++; end
    chk("code_valid_seen", code_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy || tx_frame) && n < 300) begin @(negedge clk); n++; end
    chk("drain_empty", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] s;
    logic [7:0] d;
    if (rst) begin
      flen = 0; glen = 0; started = 0; prev_frame = 0; last_gap = -1;
    end else begin
      if (code_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_code_valid: got code %0h expected none", code_out);
        end else begin
          e = q.pop_front();
          chk("code", code_out, e.code);
          model_dec(code_out, s, d);
          chk("syndrome", s, e.syn);
          chk("decoded", d, e.data);
        end
        chk("cv_with_frame_start", {prev_frame, tx_frame}, 2'b01);
        last_code = code_out;
      end
      if (tx_frame) begin
        if (!prev_frame) begin
          if (started) begin
            last_gap = glen;
            chk("gap_min", glen >= GAP_CYCLES, 1);
          end
          glen = 0;
        end
        if (flen < 12) ser[flen] = tx_bit;
        flen++;
      end else begin
        if (prev_frame) begin
          chk("frame_len", flen, 12);
          chk("serial", ser, last_code);
          flen = 0;
          started = 1;
        end
        glen++;
      end
      prev_frame = tx_frame;
    end
  end

  initial begin
    int n;
    bit bad;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 0;
    send(8'hA5, 0, 0); wait_cv(); chk("A5_code", code_out, 12'hA27); drain();
    send(8'h00, 0, 0); wait_cv(); chk("00_code", code_out, 12'h000); drain();
    send(8'hFF, 0, 0); wait_cv(); chk("FF_code", code_out, 12'hF77); drain();
    send(8'h3C, 0, 0);
    send(8'hC3, 0, 0);
    n = 0; bad = 0;
    while (!code_valid && n < 40) begin
      if (in_ready) bad = 1;
      @(negedge clk); n++;
    end
    chk("b2b_ready_low", bad, 0);
    chk("b2b_second_load", code_valid, 1);
    chk("b2b_ready_after_load", in_ready, 1);
    @(negedge clk);
    chk("b2b_gap", last_gap, GAP_CYCLES);
    drain();
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1;
    q.delete();
    @(negedge clk);
    chk_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (30) @(negedge clk);
    chk("post_reset_idle", {busy, tx_frame, in_ready}, 3'b001);
`ifdef HAMMING_TX_ERR_INJ_EN
    send(8'hA5, 1, 4'd5); wait_cv(); chk("inj5_code", code_out, 12'hA37); drain();
    send(8'hA5, 1, 4'd0); wait_cv(); chk("inj0_code", code_out, 12'hA27); drain();
    send(8'hA5, 1, 4'd13); wait_cv(); chk("inj13_code", code_out, 12'hA27); drain();
`endif
    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom), 1'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
